// File: rtl/core_pkg.sv
// Shared MEM-stage definitions: RV32I funct3 width codes, responder FSM states and the latched request.
package core_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_MERGE, ST_RESP} dmem_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} dmem_size_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // Unused funct3 codes fall through to word accesses.
    function automatic dmem_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_B;
            F3_LH, F3_LHU: return SZ_H;
            default:       return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3_size(f3))
            SZ_H:    return lo[0];
            SZ_W:    return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port 32-bit data RAM with registered read.
module dmem_ram #(
    parameter int    AW       = 11,
    parameter string INIT_HEX = ""
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [2**AW];
    logic [31:0] rdata_q;

    // Read-first on a same-address write.
    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: RV32I byte-lane loads/stores over valid/ready, RMW for SB/SH.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses complete with rsp_err instead of being aligned.
//
//  state    | meaning
//  ST_IDLE  | ready; SW written on the accept edge
//  ST_READ  | RAM read of the latched word address
//  ST_MERGE | new lanes merged into old word, written at end of cycle
//  ST_RESP  | one-cycle rsp_valid
module dmem_responder
    import core_pkg::*;
#(
    parameter int    ADDR_W   = 13,
    parameter string INIT_HEX = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int WORD_AW = ADDR_W - 2;

    dmem_state_t        state_q, state_d;
    dmem_req_t          req_q, req_d;
    logic [WORD_AW-1:0] ram_addr;
    logic               ram_we;
    logic [31:0]        ram_wdata, ram_rdata;
    logic [31:0]        merged, loaded;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic               accept, trap_new, trap_cur;
    logic               unused_addr_hi;

    assign accept = req_valid && (state_q == ST_IDLE);

`ifdef MISALIGN_TRAP_EN
    assign trap_new = is_misaligned(req_funct3, req_addr[1:0]);
    assign trap_cur = is_misaligned(req_q.funct3, req_q.addr[1:0]);
`else
    assign trap_new = 1'b0;
    assign trap_cur = 1'b0;
`endif

    always_comb begin
        merged = ram_rdata;
        case (f3_size(req_q.funct3))
            SZ_B:    merged[{req_q.addr[1:0], 3'b000} +: 8] = req_q.wdata[7:0];
            SZ_H:    merged[{req_q.addr[1], 4'b0000} +: 16] = req_q.wdata[15:0];
            default: merged = req_q.wdata;
        endcase
    end

    always_comb begin
        lane_b = ram_rdata[{req_q.addr[1:0], 3'b000} +: 8];
        lane_h = ram_rdata[{req_q.addr[1], 4'b0000} +: 16];
        case (req_q.funct3)
            F3_LB:   loaded = {{24{lane_b[7]}}, lane_b};
            F3_LBU:  loaded = {24'h000000, lane_b};
            F3_LH:   loaded = {{16{lane_h[15]}}, lane_h};
            F3_LHU:  loaded = {16'h0000, lane_h};
            default: loaded = ram_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        ram_we    = 1'b0;
        ram_wdata = merged;
        ram_addr  = req_q.addr[ADDR_W-1:2];
        case (state_q)
            ST_IDLE: begin
                ram_addr  = req_addr[ADDR_W-1:2];
                ram_wdata = req_wdata;
                if (accept) begin
                    req_d = '{we: req_we, funct3: req_funct3, addr: 32'(req_addr), wdata: req_wdata};
                    if (trap_new) begin
                        state_d = ST_RESP;
                    end else if (!req_we) begin
                        state_d = ST_READ;
                    end else if (f3_size(req_funct3) == SZ_W) begin
                        ram_we  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:  state_d = req_q.we ? ST_MERGE : ST_RESP;
            ST_MERGE: begin
                ram_we  = 1'b1;
                state_d = ST_RESP;
            end
            default:  state_d = ST_IDLE;
        endcase
        // A write due on a reset edge is dropped along with the operation.
        if (reset) ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
        req_q <= req_d;
    end

    dmem_ram #(
        .AW       (WORD_AW),
        .INIT_HEX (INIT_HEX)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid && trap_cur;
    assign rsp_rdata = (rsp_valid && !req_q.we && !trap_cur) ? loaded : 32'h0;

    assign unused_addr_hi = ^req_q.addr[31:ADDR_W];

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array memory model with per-cycle output checks plus directed literals.
module tb_dmem_responder;

    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic              req_ready, rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;

    dmem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [7:0]  mb [0:255];
    rsp_t        exp_q[$];
    int          busy_until = -1;
    bit          pend = 1'b0;
    int          pend_cyc, pend_addr, pend_size;
    logic [31:0] pend_data;
    bit          mon_en = 1'b0;
    bit          acc_flag = 1'b0;
    int          rsp_cnt = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;

    bit          m_ev, m_tr;
    rsp_t        m_e;
    int          m_a, m_sz, m_lat;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic int sz_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit trap_of(input logic [2:0] f3, input int a);
`ifdef MISALIGN_TRAP_EN
        return (a % sz_of(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
        int          sz = sz_of(f3);
        int          base = (a / sz) * sz;
        logic [31:0] v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mb[base + i]) << (8 * i));
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            m_ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("req_ready", 32'(req_ready), 32'(cyc > busy_until));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_ev));
            if (m_ev) begin
                m_e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, m_e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(m_e.err));
            end else begin
                chk("idle_rdata", rsp_rdata, 32'h0);
                chk("idle_err", 32'(rsp_err), 32'h0);
            end
            if (rsp_valid) begin
                rsp_cnt++;
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
            end
            if (reset) begin
                exp_q.delete();
                pend       = 1'b0;
                busy_until = cyc;
            end else begin
                if (pend && cyc == pend_cyc) begin
                    for (int i = 0; i < pend_size; i++) mb[pend_addr + i] = pend_data[8*i +: 8];
                    pend = 1'b0;
                end
                if (req_valid && cyc > busy_until) begin
                    m_a  = int'(req_addr);
                    m_sz = sz_of(req_funct3);
                    m_tr = trap_of(req_funct3, m_a);
                    if (m_tr)             m_lat = 1;
                    else if (!req_we)     m_lat = 2;
                    else if (m_sz == 4)   m_lat = 1;
                    else                  m_lat = 3;
                    m_e.cyc   = cyc + m_lat;
                    m_e.err   = m_tr;
                    m_e.rdata = (!req_we && !m_tr) ? model_load(req_funct3, m_a) : 32'h0;
                    exp_q.push_back(m_e);
                    busy_until = cyc + m_lat;
                    if (req_we && !m_tr) begin
                        pend_addr = (m_a / m_sz) * m_sz;
                        pend_size = m_sz;
                        pend_data = req_wdata;
                        if (m_sz == 4) begin
                            for (int i = 0; i < 4; i++) mb[pend_addr + i] = pend_data[8*i +: 8];
                        end else begin
                            pend     = 1'b1;
                            pend_cyc = cyc + 2;
                        end
                    end
                    acc_flag = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input int a, input logic [31:0] d);
        int n = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = ADDR_W'(a);
        req_wdata  = d;
        acc_flag   = 1'b0;
        while (!acc_flag && n < 40) begin
            step();
            n++;
        end
        n_vec++;
        if (!acc_flag) begin
            n_err++;
            $display("FAIL accept_timeout: addr %h not accepted, waited %0d cycles, required within 40", a, n);
        end
        acc_flag = 1'b0;
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input int a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
        int c0 = rsp_cnt;
        int n = 0;
        issue(we, f3, a, d);
        req_valid = 1'b0;
        while (rsp_cnt == c0 && n < 40) begin
            step();
            n++;
        end
        n_vec++;
        if (rsp_cnt == c0) begin
            n_err++;
            $display("FAIL rsp_timeout: addr %h got no rsp_valid in %0d cycles, required one", a, n);
        end
        rd = last_rdata;
        er = last_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        repeat (2) @(posedge clk);
        #2;
        mon_en = 1'b1;
        step();
        reset = 1'b0;

        for (int w = 0; w < 64; w++) issue(1'b1, 3'b010, 4 * w, $urandom);
        req_valid = 1'b0;
        repeat (2) step();

        xact(1'b1, 3'b010, 'h010, 32'hDEADBEEF, rd, er);
        chk("t1_sw_rdata", rd, 32'h0);
        xact(1'b0, 3'b010, 'h010, 32'h0, rd, er);
        chk("t1_lw", rd, 32'hDEADBEEF);

        xact(1'b1, 3'b010, 'h010, 32'h11223344, rd, er);
        xact(1'b1, 3'b000, 'h013, 32'h00000080, rd, er);
        xact(1'b0, 3'b010, 'h010, 32'h0, rd, er);
        chk("t2_lw", rd, 32'h80223344);
        xact(1'b0, 3'b000, 'h013, 32'h0, rd, er);
        chk("t2_lb", rd, 32'hFFFFFF80);
        xact(1'b0, 3'b100, 'h013, 32'h0, rd, er);
        chk("t2_lbu", rd, 32'h00000080);

        xact(1'b1, 3'b010, 'h014, 32'h0, rd, er);
        xact(1'b1, 3'b001, 'h016, 32'h0000ABCD, rd, er);
        xact(1'b0, 3'b010, 'h014, 32'h0, rd, er);
        chk("t3_lw", rd, 32'hABCD0000);
        xact(1'b0, 3'b001, 'h016, 32'h0, rd, er);
        chk("t3_lh", rd, 32'hFFFFABCD);
        xact(1'b0, 3'b101, 'h016, 32'h0, rd, er);
        chk("t3_lhu", rd, 32'h0000ABCD);

        xact(1'b0, 3'b010, 'h011, 32'h0, rd, er);
`ifdef MISALIGN_TRAP_EN
        chk("t6_err", 32'(er), 32'h1);
        chk("t6_rdata", rd, 32'h0);
`else
        chk("t6_err", 32'(er), 32'h0);
        chk("t6_rdata", rd, 32'h80223344);
`endif

        xact(1'b1, 3'b010, 'h020, 32'hCAFEF00D, rd, er);
        issue(1'b1, 3'b000, 'h020, 32'h00000055);
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rsp_dropped", 32'(rsp_valid), 32'h0);
        chk("t5_ready", 32'(req_ready), 32'h1);
        xact(1'b0, 3'b010, 'h020, 32'h0, rd, er);
        chk("t5_lw_prestore", rd, 32'hCAFEF00D);

        for (int i = 0; i < 600; i++) begin
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), int'($urandom_range(0, 255)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) step();
            end
            if ($urandom_range(0, 39) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 2)) step();
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
        end
        req_valid = 1'b0;
        repeat (6) step();
        chk("rsp_queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
